fbuf_arbiter: RTL and testbench
===============================

FBUF_ARBITER -- requirements
Module: fbuf_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, framebuffer word-address width (512 x 16-bit words).
REQ-002 SHALL have parameter DATA_W, default 16, framebuffer word width in pixels.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port res  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port hires  in  1  selects clear length: 1 = 512 words, 0 = 128 words.
REQ-006 SHALL have port disp_addr  in  ADDR_W  display scan read address.
REQ-007 SHALL have port disp_data  out  DATA_W  registered display read data.
REQ-008 SHALL have port cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-009 SHALL have ports cpu_we  in  1  write, and cpu_xor  in  1  XOR read-modify-write (valid only with cpu_we).
REQ-010 SHALL have ports cpu_addr  in  ADDR_W, and cpu_wdata  in  DATA_W.
REQ-011 SHALL have ports cpu_ack  out  1  one-cycle completion pulse, and cpu_rdata  out  DATA_W  read or pre-XOR data.
REQ-012 SHALL have port cpu_collision  out  1  sprite collision flag of last XOR.
REQ-013 SHALL have ports clr_req  in  1  clear pulse, and clr_busy  out  1  clear in progress.
REQ-014 SHALL have ports ram_addr  out  ADDR_W, ram_we  out  1, ram_wdata  out  DATA_W, ram_rdata  in  DATA_W (synchronous RAM, 1-cycle read latency).

Function
REQ-015 SHALL keep phase bit toggling every cycle; phase 0 = display slot, phase 1 = CPU/clear slot.
REQ-016 Phase 0: ram_addr = disp_addr, ram_we = 0; disp_data SHALL load ram_rdata at the following edge (2-cycle addr-to-data latency); disp_data otherwise holds.
REQ-017 FSM states: IDLE, RD_WAIT, XOR_WAIT, XOR_WR, CLEAR; only phase-1 cycles issue RAM accesses.
REQ-018 IDLE, phase 1, cpu_req high, cpu_ack low, no clear pending: cpu_addr/we/xor/wdata SHALL be latched and the access issued in that cycle (t).
REQ-019 Plain write: ram_we = 1, ram_wdata = cpu_wdata at t; cpu_ack high at t+1.
REQ-020 Read: read issued at t; cpu_rdata = ram_rdata captured at t+1 edge; cpu_ack high at t+2.
REQ-021 XOR: read at t; old word captured at t+1; write old ^ wdata at t+2; cpu_ack high at t+3; cpu_rdata = old word.
REQ-022 No new CPU access SHALL be issued in a cycle where cpu_ack is high.
REQ-023 clr_req SHALL be latched as pending at any time; pending clear SHALL start from IDLE before any cpu_req (priority over CPU).
REQ-024 CLEAR: hires sampled at start; writes 0 to addresses 0..N-1 (N = 512 or 128), one per phase-1 slot, ascending; clr_busy high from acceptance until cycle after last write; clr_req while busy ignored.
REQ-025 Address arithmetic SHALL be ADDR_W bits; clear counter SHALL stop at N-1, never wrap.

Reset
REQ-026 On res: phase = 0, FSM = IDLE, clear pending = 0, disp_data = 0, cpu_rdata = 0, cpu_ack = 0, cpu_collision = 0, clr_busy = 0.
REQ-027 ram_we SHALL be 0 while res is high; an in-flight XOR or clear SHALL be abandoned with no further RAM write.

Configuration
REQ-028 With FBUF_COLLISION_EN defined: cpu_collision SHALL update at XOR completion to |(old & cpu_wdata), holding until next XOR completes.
REQ-029 Without FBUF_COLLISION_EN: cpu_collision SHALL be constant 0; XOR function unchanged.

Verification
REQ-030 Read of address 0x005 preloaded 0xA5A5 in IDLE phase 1 -> cpu_ack two cycles later, cpu_rdata = 0xA5A5, no ram_we.
REQ-031 XOR 0x0F0F onto 0x00FF at address 0x010 -> RAM word 0x0FF0 at t+2, cpu_rdata = 0x00FF, cpu_collision = 1 (0 without FBUF_COLLISION_EN), ack at t+3.
REQ-032 clr_req with hires = 0 -> exactly 128 zero writes at 0x000..0x07F on phase-1 cycles only, clr_busy high 256 cycles; words 0x080+ untouched.
REQ-033 clr_req and cpu_req same cycle -> clear completes first, then CPU access acked; disp_data keeps tracking disp_addr with 2-cycle latency throughout.
REQ-034 res asserted at XOR_WAIT -> no write to target address, all outputs at reset values next cycle.

Source files
------------

// File: rtl/fbuf_arbiter.sv
// Framebuffer RAM arbiter: even cycles serve display scan, odd cycles serve CPU read/write/XOR or bulk clear.
// Build option: define FBUF_COLLISION_EN to report sprite collisions (old & new) on XOR writes.
module fbuf_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              hires,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_xor,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_collision,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, XOR_WAIT, XOR_WR, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_HI = ADDR_W'(511);
  localparam logic [ADDR_W-1:0] LAST_LO = ADDR_W'(127);

  state_t            r_state, w_next;
  logic              r_phase, r_clr_pend, r_clr_done, r_hires, r_ack;
  logic [ADDR_W-1:0] r_addr, r_cnt;
  logic [DATA_W-1:0] r_wdata, r_rdata, r_disp;
  logic              w_clr_pend, w_issue, w_clr_start, w_last;

  // A clr_req arriving this very cycle already outranks a CPU request.
  assign w_clr_pend  = r_clr_pend | clr_req;
  assign w_issue     = r_phase && (r_state == IDLE) && cpu_req && !r_ack && !w_clr_pend;
  assign w_clr_start = !r_phase && (r_state == IDLE) && w_clr_pend;
  assign w_last      = (r_cnt == (r_hires ? LAST_HI : LAST_LO));

  assign disp_data = r_disp;
  assign cpu_ack   = r_ack;
  assign cpu_rdata = r_rdata;
  assign clr_busy  = (r_state == CLEAR);

  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    ram_addr  = disp_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_clr_start) begin
          w_next = CLEAR;
        end else if (w_issue) begin
          ram_addr  = cpu_addr;
          ram_wdata = cpu_wdata;
          if (!cpu_we)      w_next = RD_WAIT;
          else if (cpu_xor) w_next = XOR_WAIT;
          else              ram_we = 1'b1;
        end
      end
      RD_WAIT:  w_next = IDLE;
      XOR_WAIT: w_next = XOR_WR;
      XOR_WR: begin
        ram_addr  = r_addr;
        ram_we    = 1'b1;
        ram_wdata = r_rdata ^ r_wdata;
        w_next    = IDLE;
      end
      CLEAR: begin
        if (r_phase) begin
          ram_addr = r_cnt;
          ram_we   = 1'b1;
        end else if (r_clr_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (res) ram_we = 1'b0;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_phase    <= 1'b0;
      r_clr_pend <= 1'b0;
      r_clr_done <= 1'b0;
      r_hires    <= 1'b0;
      r_ack      <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_disp     <= '0;
    end else begin
      r_phase <= ~r_phase;
      r_ack   <= 1'b0;
      // Odd-cycle ram_rdata always carries the previous even-cycle display read.
      if (r_phase) r_disp <= ram_rdata;
      if (w_issue) begin
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        if (cpu_we && !cpu_xor) r_ack <= 1'b1;
      end
      if (clr_req && r_state != CLEAR) r_clr_pend <= 1'b1;
      if (w_clr_start) begin
        r_clr_pend <= 1'b0;
        r_clr_done <= 1'b0;
        r_hires    <= hires;
        r_cnt      <= '0;
      end
      case (r_state)
        RD_WAIT: begin
          r_rdata <= ram_rdata;
          r_ack   <= 1'b1;
        end
        XOR_WAIT: r_rdata <= ram_rdata;
        XOR_WR:   r_ack   <= 1'b1;
        CLEAR: begin
          if (r_phase) begin
            if (w_last) r_clr_done <= 1'b1;
            else        r_cnt      <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FBUF_COLLISION_EN
  logic r_coll;
  always_ff @(posedge clk or posedge res) begin
    if (res)                     r_coll <= 1'b0;
    else if (r_state == XOR_WR)  r_coll <= |(r_rdata & r_wdata);
  end
  assign cpu_collision = r_coll;
`else
  assign cpu_collision = 1'b0;
`endif

endmodule

// File: tb/tb_fbuf_arbiter.sv
// Self-checking bench for fbuf_arbiter: behavioural RAM + transaction-level memory model.
module tb_fbuf_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;
`ifdef FBUF_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic          clk = 1'b0, res = 1'b1, hires = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, cpu_xor = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack, cpu_collision;
  logic [DW-1:0] cpu_rdata;
  logic          clr_req = 1'b0, clr_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  typedef struct {int c; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

  int            checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] mem     [512];
  logic [DW-1:0] ref_mem [512];
  logic          ref_coll = 1'b0;
  wr_t           wq[$];

  fbuf_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .res(res), .hires(hires), .disp_addr(disp_addr), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_xor(cpu_xor), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_collision(cpu_collision), .clr_req(clr_req), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write, with a log of every write and its cycle.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] = ram_wdata;
      wq.push_back('{cyc, ram_addr, ram_wdata});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic mem_cmp(input string tag);
    int bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic disp_check(input logic [AW-1:0] a, input string tag);
    disp_addr = a;
    repeat (4) tick;
    chk(tag, disp_data, ref_mem[a]);
  endtask

  // One CPU transaction, issued in an odd (CPU) slot and held until acknowledged.
  task automatic cpu_op(input logic we, input logic xr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
    int n, t, w0, exp_lat;
    logic [DW-1:0] old;
    if (cyc % 2 == 0) tick;
    old     = ref_mem[a];
    exp_lat = !we ? 2 : (xr ? 3 : 1);
    w0      = wq.size();
    t       = cyc;
    cpu_req = 1'b1; cpu_we = we; cpu_xor = xr; cpu_addr = a; cpu_wdata = d;
    n = 0;
    do begin tick; n++; end while (!cpu_ack && n < 20);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_xor = 1'b0;
    if (we && !xr) ref_mem[a] = d;
    if (we && xr) begin
      ref_mem[a] = old ^ d;
      ref_coll   = COLL & (|(old & d));
    end
    chk({tag, " ack latency"}, n, exp_lat);
    if (!we || xr) chk({tag, " rdata"}, cpu_rdata, old);
    chk({tag, " collision"}, cpu_collision, ref_coll);
    chk({tag, " write count"}, wq.size() - w0, we ? 1 : 0);
    if (we && wq.size() > w0) begin
      chk({tag, " write addr"}, wq[w0].a, a);
      chk({tag, " write data"}, wq[w0].d, ref_mem[a]);
      chk({tag, " write cycle"}, wq[w0].c, t + (xr ? 2 : 0));
    end
    tick;
  endtask

  initial begin
    int n, busy_cnt, bad, op;
    bit seen, acked;
    logic [AW-1:0] ra;

    for (int i = 0; i < 512; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[5]  = 16'hA5A5; ref_mem[5]  = 16'hA5A5;
    mem[16] = 16'h00FF; ref_mem[16] = 16'h00FF;
    mem[0]  = 16'h1111; ref_mem[0]  = 16'h1111;
    mem[32] = 16'h2222; ref_mem[32] = 16'h2222;

    repeat (3) @(posedge clk);
    #1;
    chk("reset disp_data", disp_data, 0);
    chk("reset cpu_ack", cpu_ack, 0);
    chk("reset cpu_rdata", cpu_rdata, 0);
    chk("reset collision", cpu_collision, 0);
    chk("reset clr_busy", clr_busy, 0);
    chk("reset ram_we", ram_we, 0);
    res = 1'b0;
    cyc = 0;

    // Display latency: address presented in an even cycle shows up two cycles later.
    tick; tick;
    disp_addr = 9'h020;
    tick;
    chk("disp hold", disp_data, 16'h1111);
    tick;
    chk("disp 2-cycle latency", disp_data, 16'h2222);

    cpu_op(1'b0, 1'b0, 9'h005, 16'h0000, "read 0x005");
    chk("read 0x005 value", cpu_rdata, 16'hA5A5);
    cpu_op(1'b1, 1'b1, 9'h010, 16'h0F0F, "xor 0x010");
    chk("xor result word", mem[16], 16'h0FF0);
    chk("xor collision", cpu_collision, COLL);

    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 2);
      ra = AW'($urandom);
      cpu_op(op != 0, op == 2, ra, DW'($urandom), $sformatf("rand op%0d", k));
      if (k % 8 == 7) disp_check(AW'($urandom), "rand disp");
    end
    mem_cmp("rand mem image");

    // Low-res clear with a redundant clr_req in the middle of it.
    wq.delete();
    hires = 1'b0;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    busy_cnt = 0; seen = 1'b0; n = 0;
    while (n < 700) begin
      clr_req = 1'b0;
      if (clr_busy) begin
        busy_cnt++; seen = 1'b1;
        if (busy_cnt == 100) clr_req = 1'b1;
      end else if (seen) break;
      tick; n++;
    end
    clr_req = 1'b0;
    chk("clear lo busy cycles", busy_cnt, 256);
    chk("clear lo write count", wq.size(), 128);
    bad = 0;
    foreach (wq[i]) if (wq[i].a !== AW'(i) || wq[i].d !== '0 || wq[i].c % 2 != 1) bad++;
    chk("clear lo order/data/slot", bad, 0);
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    mem_cmp("clear lo mem image");
    busy_cnt = 0;
    repeat (10) begin tick; if (clr_busy) busy_cnt++; end
    chk("clear while busy ignored", busy_cnt, 0);
    chk("clear no extra writes", wq.size(), 128);

    // Clear and CPU write requested together: clear (hi-res) must finish first.
    cpu_op(1'b1, 1'b0, 9'h1A3, 16'hBEEF, "pre write 0x1A3");
    disp_addr = 9'h1A3;
    if (cyc % 2 == 0) tick;
    wq.delete();
    hires = 1'b1;
    clr_req = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_xor = 1'b0; cpu_addr = 9'h1A3; cpu_wdata = 16'h1234;
    tick;
    clr_req = 1'b0;
    busy_cnt = 0; acked = 1'b0; n = 0;
    while (n < 1500) begin
      if (clr_busy) begin
        busy_cnt++;
        hires = 1'b0;
        if (busy_cnt == 200) chk("disp during clear", disp_data, 16'hBEEF);
      end
      if (cpu_ack) begin
        acked = 1'b1;
        chk("ack after clear done", clr_busy, 0);
        break;
      end
      tick; n++;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("combo ack seen", acked, 1);
    chk("clear hi busy cycles", busy_cnt, 1024);
    chk("combo write count", wq.size(), 513);
    bad = 0;
    for (int i = 0; i < 512 && i < wq.size(); i++)
      if (wq[i].a !== AW'(i) || wq[i].d !== '0 || wq[i].c % 2 != 1) bad++;
    chk("clear hi order/data/slot", bad, 0);
    if (wq.size() > 512) begin
      chk("combo cpu write addr", wq[512].a, 9'h1A3);
      chk("combo cpu write data", wq[512].d, 16'h1234);
    end
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    ref_mem[9'h1A3] = 16'h1234;
    tick;
    mem_cmp("combo mem image");
    disp_check(9'h1A3, "disp after combo");

    // Give the XOR target a recognisable value, then reset while the XOR is in flight.
    cpu_op(1'b1, 1'b0, 9'h040, 16'h5A5A, "pre write 0x040");
    cpu_op(1'b1, 1'b1, 9'h041, 16'hFFFF, "xor 0x041");
    if (cyc % 2 == 0) tick;
    wq.delete();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_xor = 1'b1; cpu_addr = 9'h040; cpu_wdata = 16'hFFFF;
    tick;
    res = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_xor = 1'b0;
    #1;
    chk("ram_we in reset", ram_we, 0);
    tick; tick;
    chk("abort disp_data", disp_data, 0);
    chk("abort cpu_ack", cpu_ack, 0);
    chk("abort cpu_rdata", cpu_rdata, 0);
    chk("abort collision", cpu_collision, 0);
    chk("abort clr_busy", clr_busy, 0);
    chk("abort no writes", wq.size(), 0);
    res = 1'b0;
    cyc = 0;
    ref_coll = 1'b0;
    tick; tick;
    chk("abort post-release writes", wq.size(), 0);
    mem_cmp("abort mem image");
    cpu_op(1'b0, 1'b0, 9'h040, 16'h0000, "read after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
